// File: rtl/mp_pkg.sv
// rtl/mp_pkg.sv - shared types and header field layout for the MP LUT coefficient loader
package mp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } loader_state_t;

    localparam logic [7:0] MAGIC     = 8'hC0;
    localparam int         MAGIC_MSB = 31;
    localparam int         MAGIC_LSB = 24;
    localparam int         NUM_LSB   = 0;

endpackage

// File: rtl/mp_coeff_loader.sv
// rtl/mp_coeff_loader.sv - AXI-Stream framed coefficient tables to LUT write strobes
module mp_coeff_loader
    import mp_pkg::*;
#(
    parameter int M           = 3,
    parameter int RESOLUTION  = 4096,
    parameter int COEFF_WIDTH = $clog2(RESOLUTION),
    parameter int NUM_WIDTH   = $clog2(M) + 1
) (
    input  logic                   AXI_clk_i,
    input  logic                   reset_n_i,
    input  logic                   enable_i,
    input  logic                   clr_err_i,
    input  logic [31:0]            s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic [31:0]            coeff_data_o,
    output logic [COEFF_WIDTH-1:0] coeff_addr_o,
    output logic [NUM_WIDTH-1:0]   coeff_num_o,
    output logic                   coeff_en_o,
    output logic                   busy_o,
    output logic                   load_done_o,
    output logic                   load_err_o
);

    localparam int CNT_W = COEFF_WIDTH + 1;

    loader_state_t        state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [NUM_WIDTH-1:0] num_r, num_next;
    logic                 wr, done, err_set, accept, header_ok, cnt_last;
    logic [NUM_WIDTH-1:0] hdr_num;

    assign s_axis_tready = enable_i & reset_n_i;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign busy_o        = (state != IDLE);
    assign hdr_num       = s_axis_tdata[NUM_LSB +: NUM_WIDTH];
    assign header_ok     = (s_axis_tdata[MAGIC_MSB:MAGIC_LSB] == MAGIC) &&
                           (hdr_num <= NUM_WIDTH'(M));
    assign cnt_last      = (cnt == CNT_W'(RESOLUTION - 1));

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        num_next   = num_r;
        wr         = 1'b0;
        done       = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (header_ok && !s_axis_tlast) begin
                        state_next = LOAD;
                        num_next   = hdr_num;
                        cnt_next   = '0;
                    end else begin
                        err_set    = 1'b1;
                        state_next = s_axis_tlast ? IDLE : DRAIN;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    wr       = 1'b1;
                    cnt_next = cnt + CNT_W'(1);
                    if (cnt_last) begin
                        if (s_axis_tlast) begin
                            done       = 1'b1;
                            state_next = IDLE;
                        end else begin
                            err_set    = 1'b1;
                            state_next = DRAIN;
                        end
                    end else if (s_axis_tlast) begin
                        // Short frame: the partial table already written is left in place.
                        err_set    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (accept && s_axis_tlast) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge AXI_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= IDLE;
            cnt          <= '0;
            num_r        <= '0;
            coeff_data_o <= '0;
            coeff_addr_o <= '0;
            coeff_num_o  <= '0;
            coeff_en_o   <= 1'b0;
            load_done_o  <= 1'b0;
            load_err_o   <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            num_r       <= num_next;
            coeff_en_o  <= wr;
            load_done_o <= done;
            if (wr) begin
                coeff_data_o <= s_axis_tdata;
                coeff_addr_o <= cnt[COEFF_WIDTH-1:0];
                coeff_num_o  <= num_r;
            end
            // A new error takes priority over a simultaneous clear.
            if (err_set)        load_err_o <= 1'b1;
            else if (clr_err_i) load_err_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mp_coeff_loader.sv
// tb/tb_mp_coeff_loader.sv - directed self-checking bench for mp_coeff_loader (M=3, RESOLUTION=16)
`timescale 1ns/1ps
module tb_mp_coeff_loader;

    localparam int M   = 3;
    localparam int RES = 16;
    localparam int CW  = 4;
    localparam int NW  = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          clr_err;
    logic [31:0]   tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;
    logic [31:0]   coeff_data;
    logic [CW-1:0] coeff_addr;
    logic [NW-1:0] coeff_num;
    logic          coeff_en;
    logic          busy;
    logic          load_done;
    logic          load_err;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int done_no_en = 0;
    logic [NW+CW+31:0] wq[$];

    always #5 clk = ~clk;

    mp_coeff_loader #(.M(M), .RESOLUTION(RES)) dut (
        .AXI_clk_i     (clk),
        .reset_n_i     (rst_n),
        .enable_i      (enable),
        .clr_err_i     (clr_err),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tlast  (tlast),
        .s_axis_tready (tready),
        .coeff_data_o  (coeff_data),
        .coeff_addr_o  (coeff_addr),
        .coeff_num_o   (coeff_num),
        .coeff_en_o    (coeff_en),
        .busy_o        (busy),
        .load_done_o   (load_done),
        .load_err_o    (load_err)
    );

    always @(negedge clk) begin
        if (coeff_en) wq.push_back({coeff_num, coeff_addr, coeff_data});
        if (load_done) begin
            done_cnt++;
            if (!coeff_en) done_no_en++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last, input logic exp_wr,
                             input int gap, input int stall);
        logic acc;
        repeat (gap) begin
            tvalid = 1'b0;
            @(posedge clk); #1;
        end
        tvalid = 1'b1;
        tdata  = d;
        tlast  = last;
        if (stall > 0) begin
            enable = 1'b0;
            repeat (stall) @(posedge clk);
            #1;
            enable = 1'b1;
        end
        acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = tready;
            @(posedge clk); #1;
        end
        if (!acc) begin
            chk("accept_timeout", 64'(acc), 64'd1);
        end else begin
            chk("wr_latency", 64'(coeff_en), 64'(exp_wr));
            if (exp_wr) chk("wr_data", 64'(coeff_data), 64'(d));
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] hdr, input int n, input logic good, input logic rnd);
        send_beat(hdr, n == 0, 1'b0, 0, 0);
        for (int k = 0; k < n; k++) begin
            send_beat(32'h0001_0000 + 32'(k), k == n - 1, good && (k < RES),
                      rnd ? int'($urandom_range(0, 2)) : 0,
                      (rnd && $urandom_range(0, 3) == 0) ? 2 : 0);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_writes(input string tag, input logic [NW-1:0] num, input int count,
                                input int dones);
        chk({tag, "_wcount"}, 64'(wq.size()), 64'(count));
        for (int k = 0; k < count && k < wq.size(); k++)
            chk({tag, "_wr"}, 64'(wq[k]), 64'({num, CW'(k), 32'h0001_0000 + 32'(k)}));
        chk({tag, "_done"}, 64'(done_cnt), 64'(dones));
        chk({tag, "_done_with_en"}, 64'(done_no_en), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        wq.delete();
        done_cnt = 0;
        done_no_en = 0;
    endtask

    task automatic pulse_clr;
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; clr_err = 1'b0;
        tdata = '0; tvalid = 1'b0; tlast = 1'b0;
        @(negedge clk);
        chk("rst_tready", 64'(tready), 64'd0);
        chk("rst_en", 64'(coeff_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(load_err), 64'd0);
        chk("rst_done", 64'(load_done), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("tready_up", 64'(tready), 64'd1);

        // 1 good load
        send_frame(32'hC000_0002, 16, 1'b1, 1'b0);
        check_writes("good", 3'd2, 16, 1);
        chk("good_err", 64'(load_err), 64'd0);

        // 2 backpressure and enable toggling
        send_frame(32'hC000_0002, 16, 1'b1, 1'b1);
        check_writes("bp", 3'd2, 16, 1);
        chk("bp_err", 64'(load_err), 64'd0);

        // 3 bad magic, then recovery
        send_frame(32'hAB00_0001, 16, 1'b0, 1'b0);
        check_writes("badhdr", 3'd0, 0, 0);
        chk("badhdr_err", 64'(load_err), 64'd1);
        pulse_clr();
        chk("clr_err", 64'(load_err), 64'd0);
        send_frame(32'hC000_0001, 16, 1'b1, 1'b0);
        check_writes("recover", 3'd1, 16, 1);
        chk("recover_err", 64'(load_err), 64'd0);

        // 4 index out of range, with clr_err in the same cycle as the error
        clr_err = 1'b1;
        send_beat(32'hC000_0004, 1'b1, 1'b0, 0, 0);
        clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_writes("idx", 3'd0, 0, 0);
        chk("idx_err_wins", 64'(load_err), 64'd1);
        pulse_clr();

        // 5 short frame
        send_frame(32'hC000_0003, 10, 1'b1, 1'b0);
        check_writes("short", 3'd3, 10, 0);
        chk("short_err", 64'(load_err), 64'd1);

        // reset mid-LOAD
        send_beat(32'hC000_0002, 1'b0, 1'b0, 0, 0);
        for (int k = 0; k < 5; k++) send_beat(32'h0001_0000 + 32'(k), 1'b0, 1'b1, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("mrst_tready", 64'(tready), 64'd0);
        chk("mrst_en", 64'(coeff_en), 64'd0);
        chk("mrst_data", 64'(coeff_data), 64'd0);
        chk("mrst_addr", 64'(coeff_addr), 64'd0);
        chk("mrst_num", 64'(coeff_num), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_err", 64'(load_err), 64'd0);
        chk("mrst_done", 64'(load_done), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        wq.delete();
        done_cnt = 0;
        done_no_en = 0;

        // 6 long frame: 16 writes, 4 drained beats
        send_beat(32'hC000_0000, 1'b0, 1'b0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            send_beat(32'h0001_0000 + 32'(k), k == 19, k < RES, 0, 0);
            if (k == 17) chk("drain_busy", 64'(busy), 64'd1);
        end
        repeat (2) @(posedge clk);
        #1;
        check_writes("long", 3'd0, 16, 0);
        chk("long_err", 64'(load_err), 64'd1);
        pulse_clr();
        chk("long_clr", 64'(load_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
